// File: rtl/pattern_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scan_pkg
// Description : Shared constants and FSM state encoding for the pattern-scan
//               controller and its round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_scan_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pattern_scan_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin winner selection. Searches the
//               request vector upward from the pointer, wrapping, and returns
//               the first set bit as one-hot and as an index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [PTR_W-1:0]   win_idx,
    output logic               any_req
);
    import pattern_scan_pkg::*;

    // Priority search starting at the pointer; first hit wins.
    always_comb begin
        int  pos;
        logic found;
        win_onehot = '0;
        win_idx    = '0;
        any_req    = |req;
        found      = 1'b0;
        pos        = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = int'(ptr) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && req[pos]) begin
                found           = 1'b1;
                win_onehot[pos] = 1'b1;
                win_idx         = PTR_W'(pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scan_ctrl
// Description : Request-driven sequencer for the pattern-scan datapath.
//               Arbitrates requesters round-robin, fetches the granted
//               pattern and scans it out one bit per cycle.
//               Optional macro PATTERN_SCAN_MSB_FIRST_EN scans MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_scan_ctrl #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3
) (
    input  logic                      CLK,
    input  logic                      CLEAR,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ*ADDR_W-1:0] SEL,
    output logic [NUM_REQ-1:0]        GNT,
    output logic                      BUSY,
    output logic [ADDR_W-1:0]         MEM_ADDR,
    input  logic [DATA_W-1:0]         MEM_DATA,
    output logic [2:0]                BIT_IDX,
    output logic                      SER_OUT,
    output logic                      SER_VALID,
    output logic                      DONE
);
    import pattern_scan_pkg::*;

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

`ifdef PATTERN_SCAN_MSB_FIRST_EN
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(DATA_W-1);
    localparam logic [IDX_W-1:0] LAST_IDX  = '0;
`else
    localparam logic [IDX_W-1:0] FIRST_IDX = '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W-1);
`endif

    state_t               state;
    state_t               state_nxt;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     ptr_after;
    logic [NUM_REQ-1:0]   arb_onehot;
    logic [PTR_W-1:0]     arb_idx;
    logic                 any_req;
    logic [ADDR_W-1:0]    sel_win;
    logic [DATA_W-1:0]    pattern;
    logic [IDX_W-1:0]     bit_idx;
    logic                 req_held;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req        (REQ),
        .ptr        (ptr),
        .win_onehot (arb_onehot),
        .win_idx    (arb_idx),
        .any_req    (any_req)
    );

    // The granted requester is still asking; dropping it aborts the scan.
    assign req_held  = |(REQ & GNT);
    assign ptr_after = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + PTR_W'(1);

    // Pick the arbitration winner's pattern index out of the packed SEL bus.
    always_comb begin
        sel_win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_onehot[i]) begin
                sel_win = SEL[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LOAD;
            LOAD:    state_nxt = req_held ? SHIFT : IDLE;
            SHIFT: begin
                if (!req_held) begin
                    state_nxt = IDLE;
                end else if (bit_idx == LAST_IDX) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, address latch, pattern capture, scan index and pointer update.
    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            GNT      <= '0;
            MEM_ADDR <= '0;
            win_idx  <= '0;
            ptr      <= '0;
            pattern  <= '0;
            bit_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        GNT      <= arb_onehot;
                        win_idx  <= arb_idx;
                        MEM_ADDR <= sel_win;
                    end
                end
                LOAD: begin
                    if (req_held) begin
                        pattern <= MEM_DATA;
                        bit_idx <= FIRST_IDX;
                    end else begin
                        GNT     <= '0;
                        bit_idx <= '0;
                        ptr     <= ptr_after;
                    end
                end
                SHIFT: begin
                    if (!req_held) begin
                        GNT     <= '0;
                        bit_idx <= '0;
                        ptr     <= ptr_after;
                    end else if (bit_idx == LAST_IDX) begin
                        bit_idx <= '0;
                    end else begin
`ifdef PATTERN_SCAN_MSB_FIRST_EN
                        bit_idx <= bit_idx - IDX_W'(1);
`else
                        bit_idx <= bit_idx + IDX_W'(1);
`endif
                    end
                end
                FIN: begin
                    GNT <= '0;
                    ptr <= ptr_after;
                end
                default: begin
                    GNT <= '0;
                end
            endcase
        end
    end

    assign BUSY      = (state != IDLE);
    assign SER_VALID = (state == SHIFT);
    assign DONE      = (state == FIN);
    assign SER_OUT   = (state == SHIFT) & pattern[bit_idx];
    assign BIT_IDX   = bit_idx;

endmodule
`default_nettype wire
